cpu_run_monitor: RTL
====================

# cpu_run_monitor

Synthesizable run monitor that sits beside `cpu` and watches its PC, register-file writeback and x0 read port. After a start pulse it runs a fixed-length observation window. It tracks retirement, writebacks and PC stalls, then issues a registered pass/fail verdict with a fail code. It generalises the fixed-timeout, PC-advanced, x0-is-zero self-check into a parametrised hardware block with stall detection.

## Interface
Parameters:
- `PC_W`, 32, PC width.
- `XLEN`, 32, register data width.
- `RA_W`, 5, register address width.
- `CNT_W`, 16, counter width; all counters saturate at 2^CNT_W-1.
- `RUN_CYCLES`, 20, length of the observation window in RUN cycles; legal range 1 ≤ RUN_CYCLES < 2^CNT_W.
- `STALL_LIMIT`, 8, number of consecutive unchanged-PC samples that ends the run as a failure; legal range 1 ≤ STALL_LIMIT < 2^CNT_W.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a run.
- `pc` in PC_W: current PC of the CPU.
- `rf_we` in 1: register-file write enable.
- `rf_waddr` in RA_W: writeback destination register.
- `x0_rdata` in XLEN: value read from register x0.
- `busy` out 1: high in RUN or CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: verdict; valid while `done` is high.
- `fail_code` out 2: 0 none, 1 STALL, 2 NO_PROGRESS, 3 X0_NONZERO.
- `cycle_cnt` out CNT_W: number of RUN cycles elapsed.
- `retire_cnt` out CNT_W: number of RUN samples where `pc` differed from the previous sample.
- `wb_cnt` out CNT_W: number of RUN samples with `rf_we` high and `rf_waddr` ≠ 0.
- `last_pc` out PC_W: most recent `pc` sampled in RUN.

## Operation
- The FSM has four states: IDLE, RUN, CHECK, DONE.
- **IDLE:**
  - `start` moves the FSM to RUN.
  - On that edge it clears all counters, `pass` and `fail_code`.
  - It also captures `start_pc` ← `pc` and `prev_pc` ← `pc`.
- **RUN, at each edge:**
  - `cycle_cnt` increments.
  - `last_pc` ← `pc`.
  - If `pc` ≠ `prev_pc`: `retire_cnt` increments and `stall_cnt` ← 0.
  - Otherwise `stall_cnt` increments.
  - `prev_pc` ← `pc`.
  - `wb_cnt` increments per the port definition; writes to x0 are never counted.
  - When `stall_cnt` reaches STALL_LIMIT: go to DONE with `fail_code`=1 and `pass`=0.
  - Otherwise, when `cycle_cnt` reaches RUN_CYCLES: go to CHECK.
  - If both conditions occur on the same edge, STALL wins.
- **CHECK** (exactly one cycle), evaluated in priority order; the FSM always moves to DONE:
  1. `last_pc` ≤ `start_pc` (unsigned) → `fail_code`=2.
  2. Else, if `CPU_MON_X0_CHECK_EN` is defined and `x0_rdata` ≠ 0 → `fail_code`=3.
  3. Else `pass`=1 and `fail_code`=0.
- **DONE:**
  - Verdict, counters and `last_pc` hold.
  - `start` restarts the run exactly as it does from IDLE.
- `start` is ignored in RUN and CHECK.
- `rst` in any state, including mid-run, returns the FSM to IDLE and zeroes every output, counter and internal register on the same edge.

## Timing
- All outputs are registered.
- Reset value of every output is 0.
- The edge that samples `start` is E0. Nominal run:
  - `busy` is high from E0 until the edge into DONE.
  - CHECK is occupied during the cycle after E_RUN_CYCLES.
  - `done`/`pass`/`fail_code` become visible after edge E_(RUN_CYCLES+1).
- Stall with `pc` frozen from E0:
  - The first stall sample is at E1.
  - `done` with `fail_code`=1 becomes visible after E_STALL_LIMIT.
- Counters saturate and never wrap.

## Configuration
- `CPU_MON_X0_CHECK_EN` defined: the x0-read check in CHECK is active and can produce `fail_code`=3.
- Undefined: `x0_rdata` is ignored and `fail_code` never takes the value 3.

## Test plan
All cases use default parameters.
- **Nominal run:** `start` pulse, then `pc` takes the values 4, 8, … 80 on successive RUN edges → `done` after E21, `pass`=1, `fail_code`=0, `cycle_cnt`=20, `retire_cnt`=20, `last_pc`=80.
- **Stall:** `pc` held at 0x10 from `start` → `done` after E8, `fail_code`=1, `cycle_cnt`=8, `retire_cnt`=0.
- **No progress:**
  - Stimulus: `start` with `pc`=0x40; `pc` increments by 4 until E19, then jumps to 0x8 at E20.
  - Response: `fail_code`=2, `pass`=0.
- **x0 check:** nominal run with `x0_rdata`=5.
  - With `CPU_MON_X0_CHECK_EN` defined → `fail_code`=3.
  - Without it → `pass`=1.
- **Writeback count:** during RUN, 3 writes to x3 and 2 writes to x0 → `wb_cnt`=3.
- **Reset and ignored start:**
  - A `start` pulse at E5 of RUN is ignored, and the run ends normally.
  - `rst` asserted at E10 of a new run → IDLE next cycle, all outputs 0; a fresh `start` then runs to `pass`=1.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - fixed-window run monitor with stall detection and pass/fail verdict
// Optional feature macro: CPU_MON_X0_CHECK_EN (enables the x0-is-zero check in CHECK)
module cpu_run_monitor #(
  parameter int PC_W        = 32,
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int CNT_W       = 16,
  parameter int RUN_CYCLES  = 20,
  parameter int STALL_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             rf_we,
  input  logic [RA_W-1:0]  rf_waddr,
  input  logic [XLEN-1:0]  x0_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [PC_W-1:0]  last_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_LIMIT);
  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_STALL = 2'd1;
  localparam logic [1:0] FC_NOPRG = 2'd2;
  localparam logic [1:0] FC_X0    = 2'd3;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [PC_W-1:0]  start_pc_q, start_pc_d;
  logic [PC_W-1:0]  prev_pc_q, prev_pc_d;

`ifndef CPU_MON_X0_CHECK_EN
  logic unused_x0;
  assign unused_x0 = ^x0_rdata;
`endif

  // Saturating increment: counters pin at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-state, counter and verdict logic.
  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    fail_code_d  = fail_code_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    last_pc_d    = last_pc_q;
    start_pc_d   = start_pc_q;
    prev_pc_d    = prev_pc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          pass_d       = 1'b0;
          fail_code_d  = FC_NONE;
          cycle_cnt_d  = '0;
          retire_cnt_d = '0;
          wb_cnt_d     = '0;
          stall_cnt_d  = '0;
          start_pc_d   = pc;
          prev_pc_d    = pc;
        end
      end
      S_RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        last_pc_d   = pc;
        prev_pc_d   = pc;
        if (pc != prev_pc_q) begin
          retire_cnt_d = sat_inc(retire_cnt_q);
          stall_cnt_d  = '0;
        end else begin
          stall_cnt_d  = sat_inc(stall_cnt_q);
        end
        if (rf_we && (rf_waddr != '0)) begin
          wb_cnt_d = sat_inc(wb_cnt_q);
        end
        // Stall takes priority over window expiry on the same edge.
        if (stall_cnt_d >= STALL_LIM) begin
          state_d     = S_DONE;
          pass_d      = 1'b0;
          fail_code_d = FC_STALL;
        end else if (cycle_cnt_d >= RUN_LIM) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        pass_d  = 1'b0;
        if (last_pc_q <= start_pc_q) begin
          fail_code_d = FC_NOPRG;
`ifdef CPU_MON_X0_CHECK_EN
        end else if (x0_rdata != '0) begin
          fail_code_d = FC_X0;
`endif
        end else begin
          pass_d      = 1'b1;
          fail_code_d = FC_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      wb_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      last_pc_q    <= '0;
      start_pc_q   <= '0;
      prev_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_code_q  <= fail_code_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      last_pc_q    <= last_pc_d;
      start_pc_q   <= start_pc_d;
      prev_pc_q    <= prev_pc_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fail_code_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign wb_cnt     = wb_cnt_q;
  assign last_pc    = last_pc_q;

endmodule
